// File: rtl/game_pkg.sv
// Shared constants for the game input path: key indices, default timing and
// the auto-repeat state encoding.
package game_pkg;

  // Bit positions within the raw key_n bus.
  localparam int unsigned KEY_START = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_RIGHT = 2;
  localparam int unsigned NUM_KEYS  = 3;

  // Default timing at 50 MHz: 10 ms debounce, 300 ms first repeat, 100 ms repeat rate.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 15000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  typedef enum logic [1:0] {
    RepIdle,
    RepDelay,
    RepRepeat
  } rep_state_e;

  // Counter width for a terminal count of n; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioning: 2-flop synchroniser, stable-sample debounce and a
// one-cycle press strobe on each debounced released->pressed transition.
module key_debounce
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          raw_pressed;

  assign raw_pressed = ~sync2_q;

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (raw_pressed == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      // Strictly below CNT_LAST here, so the increment cannot wrap.
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser, debounce state and press-edge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= key_n;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      cnt_q       <= cnt_d;
    end
  end

  assign pressed = level_q;
  assign press   = press_q;

endmodule

// File: rtl/key_conditioner.sv
// Turns three raw active-low buttons into a start strobe and a single-entry
// left/right command latch. Define KEY_AUTO_REPEAT_EN to add held-key
// auto-repeat for left/right; without it each press yields one command.
module key_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  output logic       start_pulse,
  output logic       left_cmd,
  output logic       right_cmd,
  input  logic       cmd_ack
);

  if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_timing
    $error("key_conditioner: timing parameters must be non-zero");
  end

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic                unused_start_level;

  assign unused_start_level = level[KEY_START];

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n[KEY_START]),
    .pressed (level[KEY_START]),
    .press   (press[KEY_START])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n[KEY_LEFT]),
    .pressed (level[KEY_LEFT]),
    .press   (press[KEY_LEFT])
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n[KEY_RIGHT]),
    .pressed (level[KEY_RIGHT]),
    .press   (press[KEY_RIGHT])
  );

  // Direction index 0 is left, 1 is right.
  logic [1:0] dir_level, dir_press, rep_ev;
  assign dir_level = {level[KEY_RIGHT], level[KEY_LEFT]};
  assign dir_press = {press[KEY_RIGHT], press[KEY_LEFT]};

`ifdef KEY_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW     = cnt_width(REP_MAX);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  for (genvar d = 0; d < 2; d++) begin : g_rep
    rep_state_e     state_q, state_d;
    logic [RCW-1:0] cnt_q, cnt_d;
    logic           ev;

    // Repeat FSM: a press arms the delay, then events follow at the repeat rate.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ev      = 1'b0;
      if (!dir_level[d]) begin
        state_d = RepIdle;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          RepIdle: begin
            if (dir_press[d]) begin
              state_d = RepDelay;
              cnt_d   = '0;
            end
          end
          RepDelay: begin
            if (cnt_q == DELAY_LAST) begin
              state_d = RepRepeat;
              cnt_d   = '0;
              ev      = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RepRepeat: begin
            if (cnt_q == PERIOD_LAST) begin
              cnt_d = '0;
              ev    = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = RepIdle;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Repeat FSM state and counter.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= RepIdle;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign rep_ev[d] = ev;
  end
`else
  assign rep_ev = '0;
`endif

  // A fresh simultaneous press of both keys is let through (left wins); once both
  // are held, neither direction may issue events.
  logic both_held, left_ev, right_ev;
  assign both_held = dir_level[0] & dir_level[1] & ~(dir_press[0] & dir_press[1]);
  assign left_ev   = (dir_press[0] | rep_ev[0]) & ~both_held;
  assign right_ev  = (dir_press[1] | rep_ev[1]) & ~both_held;

  logic left_q, left_d, right_q, right_d, start_q;

  // Single-entry command latch: ack frees the slot in time for a coincident event.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    if (cmd_ack) begin
      left_d  = 1'b0;
      right_d = 1'b0;
    end
    if (!(left_d || right_d)) begin
      if (left_ev) begin
        left_d = 1'b1;
      end else if (right_ev) begin
        right_d = 1'b1;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      start_q <= press[KEY_START];
    end
  end

  assign start_pulse = start_q;
  assign left_cmd    = left_q;
  assign right_cmd   = right_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Inputs change 1 ns after a rising edge; outputs are read there.
// Cycle t means "after edge t"; an input meant for cycle k is set at t=k-1.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic       cmd_ack;
  logic       start_pulse, left_cmd, right_cmd;

  int checks = 0;
  int errors = 0;
  int t      = 0;

  always #5 clk = ~clk;

  key_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .start_pulse (start_pulse),
    .left_cmd    (left_cmd),
    .right_cmd   (right_cmd),
    .cmd_ack     (cmd_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic advance_to(input int e);
    while (t < e) tick();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    key_n   = 3'b111;
    cmd_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    t     = 0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    key_n   = 3'b000;
    cmd_ack = 1'b1;
    tick();
    tick();
    checks++;
    if (start_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_start: got %b want 0", start_pulse);
    end
    checks++;
    if (left_cmd !== 1'b0) begin
      errors++; $display("FAIL rst_left: got %b want 0", left_cmd);
    end
    checks++;
    if (right_cmd !== 1'b0) begin
      errors++; $display("FAIL rst_right: got %b want 0", right_cmd);
    end
    // Ack with nothing pending must not disturb anything.
    do_reset();
    cmd_ack = 1'b1;
    advance_to(1);
    cmd_ack = 1'b0;
    advance_to(5);
    checks++;
    if ({start_pulse, left_cmd, right_cmd} !== 3'b000) begin
      errors++; $display("FAIL idle_ack: got %b want 000", {start_pulse, left_cmd, right_cmd});
    end
  endtask

  task automatic test_left_basic();
    do_reset();
    advance_to(9);
    key_n[1] = 1'b0;
    advance_to(16);
    checks++;
    if (left_cmd !== 1'b0) begin
      errors++; $display("FAIL left_early: got %b want 0 at t=16", left_cmd);
    end
    advance_to(17);
    checks++;
    if (left_cmd !== 1'b1) begin
      errors++; $display("FAIL left_rise: got %b want 1 at t=17", left_cmd);
    end
    checks++;
    if (right_cmd !== 1'b0) begin
      errors++; $display("FAIL left_right_quiet: got %b want 0", right_cmd);
    end
    advance_to(29);
    checks++;
    if (left_cmd !== 1'b1) begin
      errors++; $display("FAIL left_hold: got %b want 1 at t=29", left_cmd);
    end
    cmd_ack = 1'b1;
    advance_to(30);
    cmd_ack = 1'b0;
    advance_to(31);
    checks++;
    if (left_cmd !== 1'b0) begin
      errors++; $display("FAIL left_ack: got %b want 0 at t=31", left_cmd);
    end
    key_n[1] = 1'b1;
  endtask

  task automatic test_bounce();
    int highs = 0;
    do_reset();
    advance_to(9);
    for (int c = 0; c < 20; c++) begin
      key_n[2] = ((c / 2) % 2) != 0;
      tick();
      if (right_cmd || left_cmd || start_pulse) highs++;
    end
    key_n[2] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (right_cmd || left_cmd || start_pulse) highs++;
    end
    checks++;
    if (highs !== 0) begin
      errors++; $display("FAIL bounce: %0d output-high cycles, want 0", highs);
    end
  endtask

  task automatic test_start_single();
    int highs    = 0;
    int first_t  = -1;
    int dir_high = 0;
    do_reset();
    advance_to(9);
    key_n[0] = 1'b0;
    while (t < 130) begin
      tick();
      if (t == 109) key_n[0] = 1'b1;
      if (start_pulse) begin
        highs++;
        if (first_t < 0) first_t = t;
      end
      if (left_cmd || right_cmd) dir_high++;
    end
    checks++;
    if (highs !== 1) begin
      errors++; $display("FAIL start_count: got %0d pulse cycles want 1", highs);
    end
    checks++;
    if (first_t !== 17) begin
      errors++; $display("FAIL start_time: got t=%0d want t=17", first_t);
    end
    checks++;
    if (dir_high !== 0) begin
      errors++; $display("FAIL start_no_dir: got %0d cmd cycles want 0", dir_high);
    end
  endtask

  task automatic test_auto_repeat();
    int   rises[$];
    logic prev      = 1'b0;
    int   right_hi  = 0;
    do_reset();
    advance_to(9);
    key_n[1] = 1'b0;
    while (t < 90) begin
      tick();
      cmd_ack = 1'b0;
      if (left_cmd && !prev) begin
`ifdef KEY_AUTO_REPEAT_EN
        if (t - 10 <= 56) rises.push_back(t - 10);
`else
        rises.push_back(t - 10);
`endif
        cmd_ack = 1'b1;
      end
      prev = left_cmd;
      if (right_cmd) right_hi++;
      if (t == 69) key_n[1] = 1'b1;
    end
    cmd_ack = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
    checks++;
    if (rises.size() !== 5) begin
      errors++; $display("FAIL rep_count: got %0d rises want 5", rises.size());
    end else begin
      int exp_r[5] = '{7, 27, 35, 43, 51};
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rises[i] !== exp_r[i]) begin
          errors++; $display("FAIL rep_rise%0d: got +%0d want +%0d", i, rises[i], exp_r[i]);
        end
      end
    end
`else
    checks++;
    if (rises.size() !== 1) begin
      errors++; $display("FAIL rep_count: got %0d rises want 1", rises.size());
    end else begin
      checks++;
      if (rises[0] !== 7) begin
        errors++; $display("FAIL rep_rise0: got +%0d want +7", rises[0]);
      end
    end
`endif
    checks++;
    if (right_hi !== 0) begin
      errors++; $display("FAIL rep_right: got %0d right cycles want 0", right_hi);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    advance_to(9);
    key_n[2:1] = 2'b00;
    advance_to(17);
    checks++;
    if ({left_cmd, right_cmd} !== 2'b10) begin
      errors++; $display("FAIL simul: got l/r=%b want 10", {left_cmd, right_cmd});
    end
    advance_to(25);
    checks++;
    if ({left_cmd, right_cmd} !== 2'b10) begin
      errors++; $display("FAIL simul_hold: got l/r=%b want 10", {left_cmd, right_cmd});
    end
    key_n[2:1] = 2'b11;
  endtask

  task automatic test_drop_pending();
    int right_hi = 0;
    do_reset();
    advance_to(9);
    key_n[1] = 1'b0;
    advance_to(20);
    key_n[1] = 1'b1;
    advance_to(29);
    key_n[2] = 1'b0;
    advance_to(40);
    key_n[2] = 1'b1;
    checks++;
    if ({left_cmd, right_cmd} !== 2'b10) begin
      errors++; $display("FAIL drop_pending: got l/r=%b want 10", {left_cmd, right_cmd});
    end
    advance_to(44);
    cmd_ack = 1'b1;
    advance_to(45);
    cmd_ack = 1'b0;
    checks++;
    if (left_cmd !== 1'b0) begin
      errors++; $display("FAIL drop_ack: got %b want 0", left_cmd);
    end
    while (t < 70) begin
      tick();
      if (right_cmd) right_hi++;
    end
    checks++;
    if (right_hi !== 0) begin
      errors++; $display("FAIL drop_right: got %0d right cycles want 0", right_hi);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    advance_to(9);
    key_n[1] = 1'b0;
    advance_to(20);
    key_n[1] = 1'b1;
    advance_to(29);
    key_n[2] = 1'b0;
    advance_to(36);
    checks++;
    if ({left_cmd, right_cmd} !== 2'b10) begin
      errors++; $display("FAIL b2b_before: got l/r=%b want 10", {left_cmd, right_cmd});
    end
    cmd_ack = 1'b1;
    advance_to(37);
    cmd_ack = 1'b0;
    checks++;
    if ({left_cmd, right_cmd} !== 2'b01) begin
      errors++; $display("FAIL b2b_swap: got l/r=%b want 01", {left_cmd, right_cmd});
    end
    advance_to(40);
    checks++;
    if (right_cmd !== 1'b1) begin
      errors++; $display("FAIL b2b_hold: got %b want 1", right_cmd);
    end
    key_n[2] = 1'b1;
  endtask

  task automatic test_both_held();
    int hi = 0;
    do_reset();
    advance_to(9);
    key_n[1] = 1'b0;
    advance_to(19);
    cmd_ack = 1'b1;
    advance_to(20);
    cmd_ack = 1'b0;
    checks++;
    if (left_cmd !== 1'b0) begin
      errors++; $display("FAIL both_ack: got %b want 0", left_cmd);
    end
    advance_to(24);
    key_n[2] = 1'b0;
    while (t < 40) begin
      tick();
      if (left_cmd || right_cmd) hi++;
    end
    checks++;
    if (hi !== 0) begin
      errors++; $display("FAIL both_held: got %0d cmd cycles want 0", hi);
    end
    key_n[2:1] = 2'b11;
  endtask

  task automatic test_reset_mid_press();
    do_reset();
    advance_to(9);
    key_n[1] = 1'b0;
    advance_to(39);
    checks++;
    if (left_cmd !== 1'b1) begin
      errors++; $display("FAIL rmp_pre: got %b want 1 at t=39", left_cmd);
    end
    reset = 1'b1;
    advance_to(40);
    reset = 1'b0;
    advance_to(41);
    checks++;
    if (left_cmd !== 1'b0) begin
      errors++; $display("FAIL rmp_clear: got %b want 0 at t=41", left_cmd);
    end
    advance_to(47);
    checks++;
    if (left_cmd !== 1'b0) begin
      errors++; $display("FAIL rmp_early: got %b want 0 at t=47", left_cmd);
    end
    advance_to(48);
    checks++;
    if (left_cmd !== 1'b1) begin
      errors++; $display("FAIL rmp_reassert: got %b want 1 at t=48", left_cmd);
    end
    key_n[1] = 1'b1;
  endtask

  initial begin
    reset   = 1'b1;
    key_n   = 3'b111;
    cmd_ack = 1'b0;
    test_reset();
    test_left_basic();
    test_bounce();
    test_start_single();
    test_auto_repeat();
    test_simultaneous();
    test_drop_pending();
    test_back_to_back();
    test_both_held();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
